// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package rv_fetch_pkg;

    localparam int INST_W       = 32;
    localparam int FETCH_ADDR_W = 32;

    // Canonical RISC-V no-op (addi x0, x0, 0).
    localparam logic [INST_W-1:0] RV_NOP = 32'h0000_0013;

    // Address the core starts fetching from when the top is not overridden.
    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [INST_W-1:0]       inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_unit_if.sv
// Bundles the ROM read port, the redirect input and the decode handshake.
// The master modport is the fetch unit; the slave side is ROM, execute and decode.
interface ifu_fetch_unit_if import rv_fetch_pkg::*; #(
    parameter int ADDR_W = FETCH_ADDR_W
);

    logic              rom_req_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_rdata_i;

    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;

    logic              inst_valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_ready_i;

    modport master (
        output rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  rom_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output rom_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. A flush empties it at the clock
// edge, but a push in the same cycle still lands as the sole surviving entry.
module fetch_fifo import rv_fetch_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;
    logic [PTR_W-1:0] writeIdx;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Push is accepted when there is room, when the head leaves in the same
    // cycle, or when a flush frees everything; pop is ignored when empty.
    assign doPush   = push_i && (flush_i || !full_o || pop_i);
    assign doPop    = pop_i && !empty_o;
    assign writeIdx = flush_i ? '0 : wrPtr_q;

    // Zero the head when empty so decode never sees stale entries.
    assign head_o = empty_o ? '0 : mem[rdPtr_q];

    // Pointer and occupancy bookkeeping; flush restarts both pointers at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= doPush ? PTR_W'(1) : '0;
            count_q <= doPush ? CNT_W'(1) : '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Storage write; entries need no reset because empty_o masks the head.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[writeIdx] <= data_i;
        end
    end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-based ROM
// issue, one-cycle ROM response capture and redirect handling.
module ifu_fetch_unit import rv_fetch_pkg::*; #(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    ifu_fetch_unit_if.master   bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetchPc_q;
    logic [ADDR_W-1:0] fetchPc_d;
    logic [ADDR_W-1:0] issuePc_q;
    logic              inflight_q;

    logic [ADDR_W-1:0] redirectTarget;
    logic [ADDR_W-1:0] reqAddr;
    logic              issue;
    logic              killResponse;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;

    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    fetch_entry_t      pushEntry;
    fetch_entry_t      headEntry;

    assign redirectTarget = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign reqAddr        = bus.redirect_i ? redirectTarget : fetchPc_q;

    // A redirect discards whatever ROM word is returning this cycle; the
    // request issued alongside the redirect already targets the new stream.
    assign killResponse = bus.redirect_i;
    assign push         = inflight_q && !killResponse;
    assign pop          = !fifoEmpty && bus.inst_ready_i;

    // Credits: every outstanding ROM word has a reserved FIFO slot, so a
    // response is never dropped. The full/no-pop guard restates this for the
    // case where the FIFO alone already holds every slot.
    assign occupancy = (CNT_W+1)'(fifoCount) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue     = !rst && !(fifoFull && !pop) && (occupancy < (CNT_W+1)'(DEPTH));

    assign bus.rom_req_o  = issue;
    assign bus.rom_addr_o = reqAddr;

    assign pushEntry.pc   = FETCH_ADDR_W'(issuePc_q);
    assign pushEntry.inst = bus.rom_rdata_i;

    assign bus.inst_valid_o = !fifoEmpty;
    assign bus.inst_o       = headEntry.inst;
    assign bus.inst_pc_o    = ADDR_W'(headEntry.pc);

    // Next fetch address: advance past an issued word (wrapping naturally),
    // otherwise remember a redirect target, otherwise hold.
    always_comb begin
        fetchPc_d = fetchPc_q;
        if (issue) begin
            fetchPc_d = reqAddr + ADDR_W'(4);
        end else if (bus.redirect_i) begin
            fetchPc_d = redirectTarget;
        end
    end

    // PC, in-flight flag and issued-address capture for the one-cycle ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q  <= RESET_PC;
            inflight_q <= 1'b0;
            issuePc_q  <= '0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            inflight_q <= issue;
            if (issue) begin
                issuePc_q <= reqAddr;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_i),
        .data_i  (pushEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount),
        .head_o  (headEntry)
    );

endmodule
